// File: rtl/l1_ahb_input_hold_stage.sv
// ---------------------------------------------------------------------------
// l1_ahb_input_hold_stage
//
// Input hold stage placed between one L1 AHB bus-matrix slave interface and
// its address decoder. If the decoder says the targeted output stage is not
// active for this port when a transfer is accepted, the address-phase
// controls are captured. The upstream master is stalled with HREADYOUTS low
// while the held transfer is replayed to the decoder until the output stage
// is granted. Otherwise the address phase passes through with zero latency.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSELS..HREADYS         upstream address phase and bus HREADY
//   HREADYOUTS, HRESPS     response returned to the upstream bus
//   sel_op..lock_op        address phase presented to decoder / output stages
//   held_op                1 while the presented transfer is the held one
//   ready_op               HREADY presented to the decoder
//   active_op              decoder: output stage active for this address
//   readyout_dec, resp_dec decoder HREADYOUT / HRESP
//
// Handshake: an address phase is accepted on a clock edge where HSELS=1,
// HTRANSS is NONSEQ/SEQ and HREADYS=1. The held transfer is issued
// downstream on the edge where active_op=1 and readyout_dec=1; the upstream
// data phase of that transfer starts on the following cycle.
// ---------------------------------------------------------------------------
module l1_ahb_input_hold_stage #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned PROMOTE_SEQ = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS,
    output logic                  sel_op,
    output logic [ADDR_WIDTH-1:0] addr_op,
    output logic [1:0]            trans_op,
    output logic                  write_op,
    output logic [2:0]            size_op,
    output logic [2:0]            burst_op,
    output logic [3:0]            prot_op,
    output logic                  lock_op,
    output logic                  held_op,
    output logic                  ready_op,
    input  logic                  active_op,
    input  logic                  readyout_dec,
    input  logic [1:0]            resp_dec
);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    logic                  pend_q,      pend_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q,  reg_addr_d;
    logic [1:0]            reg_trans_q, reg_trans_d;
    logic                  reg_write_q, reg_write_d;
    logic [2:0]            reg_size_q,  reg_size_d;
    logic [2:0]            reg_burst_q, reg_burst_d;
    logic [3:0]            reg_prot_q,  reg_prot_d;
    logic                  reg_lock_q,  reg_lock_d;

    logic accept;
    logic promote;

    assign accept = HSELS & HTRANSS[1] & HREADYS;

    // Next-state for the pending flag and the holding register.
    always_comb begin
        pend_d      = pend_q;
        reg_addr_d  = reg_addr_q;
        reg_trans_d = reg_trans_q;
        reg_write_d = reg_write_q;
        reg_size_d  = reg_size_q;
        reg_burst_d = reg_burst_q;
        reg_prot_d  = reg_prot_q;
        reg_lock_d  = reg_lock_q;
        if (!pend_q) begin
            // The register shadows every completed address phase so that the
            // capture on pend 0->1 needs no separate load path.
            if (HREADYS) begin
                reg_addr_d  = HADDRS;
                reg_trans_d = HTRANSS;
                reg_write_d = HWRITES;
                reg_size_d  = HSIZES;
                reg_burst_d = HBURSTS;
                reg_prot_d  = HPROTS;
                reg_lock_d  = HMASTLOCKS;
            end
            if (accept && !active_op) begin
                pend_d = 1'b1;
            end
        end else if (active_op && readyout_dec) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_trans_q <= '0;
            reg_write_q <= 1'b0;
            reg_size_q  <= '0;
            reg_burst_q <= '0;
            reg_prot_q  <= '0;
            reg_lock_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            reg_addr_q  <= reg_addr_d;
            reg_trans_q <= reg_trans_d;
            reg_write_q <= reg_write_d;
            reg_size_q  <= reg_size_d;
            reg_burst_q <= reg_burst_d;
            reg_prot_q  <= reg_prot_d;
            reg_lock_q  <= reg_lock_d;
        end
    end

    // A replayed SEQ beat no longer follows its predecessor downstream, so it
    // is re-issued as the start of an undefined-length burst.
    assign promote = (PROMOTE_SEQ != 0) && (reg_trans_q == TRANS_SEQ);

    always_comb begin
        sel_op     = HSELS;
        addr_op    = HADDRS;
        trans_op   = HTRANSS;
        write_op   = HWRITES;
        size_op    = HSIZES;
        burst_op   = HBURSTS;
        prot_op    = HPROTS;
        lock_op    = HMASTLOCKS;
        ready_op   = HREADYS;
        held_op    = 1'b0;
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
        if (pend_q) begin
            sel_op     = 1'b1;
            addr_op    = reg_addr_q;
            trans_op   = promote ? TRANS_NONSEQ : reg_trans_q;
            write_op   = reg_write_q;
            size_op    = reg_size_q;
            burst_op   = promote ? BURST_INCR : reg_burst_q;
            prot_op    = reg_prot_q;
            lock_op    = reg_lock_q;
            // The decoder sees its own HREADYOUT so it can complete the
            // previous data phase while the held address waits.
            ready_op   = readyout_dec;
            held_op    = 1'b1;
            HREADYOUTS = 1'b0;
            HRESPS     = RESP_OKAY;
        end
    end

endmodule
